// File: rtl/mod_pkg.sv
// Shared definitions for the residue (mod 2^W - 1) datapath blocks:
// modulus helper, op encoding and the stage-1 operand payload.
package mod_pkg;

   localparam int EAC_W = 8;

   localparam logic OP_SUB = 1'b0;
   localparam logic OP_ADD = 1'b1;

   function automatic logic [31:0] MOD_M(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

   // Operands after the subtract/add inversion plus their per-bit carry terms.
   typedef struct packed {
      logic [EAC_W-1:0] a;
      logic [EAC_W-1:0] b_n;
      logic [EAC_W-1:0] g;
      logic [EAC_W-1:0] p;
      logic [EAC_W-1:0] x;
   } s1_payload_t;

endpackage

// File: rtl/mod_eac_adder.sv
// Combinational WIDTH-bit end-around-carry adder built on Ling pseudo-carries.
// The carry into each bit is taken around the full ring of WIDTH positions.
module mod_eac_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] g_i,
   input  logic [WIDTH-1:0] p_i,
   input  logic [WIDTH-1:0] x_i,
   output logic [WIDTH-1:0] sum_o
);

   logic [2*WIDTH-1:0] g2;
   logic [2*WIDTH-1:0] p2;
   logic [WIDTH-1:0]   carry;
   logic               h;
   logic               pp;

   assign g2 = {g_i, g_i};
   assign p2 = {p_i, p_i};

   // Carry into bit i spans positions i-1 down to i cyclically; the doubled
   // vectors unroll that ring, and c = p[top] & h factors out the top propagate.
   always_comb begin
      carry = '0;
      h     = 1'b0;
      pp    = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         h  = g2[i+WIDTH-1];
         pp = 1'b1;
         for (int k = i + WIDTH - 2; k >= i; k--) begin
            h  = h | (pp & g2[k]);
            pp = pp & p2[k];
         end
         carry[i] = p2[i+WIDTH-1] & h;
      end
   end

   assign sum_o = x_i ^ carry;

endmodule

// File: rtl/mod255_sub_pipe.sv
// Two-stage modulo (2^WIDTH - 1) subtract/add unit: S1 registers operands and
// carry terms, S2 registers the end-around-carry sum (optionally normalized).
module mod255_sub_pipe
   import mod_pkg::*;
#(
   parameter int WIDTH     = EAC_W,
   parameter bit NORMALIZE = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res
);

   // Handshake: a beat moves when valid && ready are both high at a rising
   // edge; a producer holds valid and data stable until that edge.
   logic             s1_valid_q, s1_valid_d;
   logic             s2_valid_q, s2_valid_d;
   s1_payload_t      s1_q, s1_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] b_n;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] norm_sum;
   logic             accept;
   logic             s2_load;
   logic             neg_zero;

   assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
   assign in_ready = !rst && (!s1_valid_q || s2_load);
   assign accept   = in_valid && in_ready;
   assign b_n      = (in_op == OP_SUB) ? ~in_b : in_b;

   always_comb begin
      s1_d       = s1_q;
      s1_valid_d = s1_valid_q;
      if (accept) begin
         s1_d.a     = in_a;
         s1_d.b_n   = b_n;
         s1_d.g     = in_a & b_n;
         s1_d.p     = in_a | b_n;
         s1_d.x     = in_a ^ b_n;
         s1_valid_d = 1'b1;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end
   end

   mod_eac_adder #(.WIDTH(WIDTH)) u_eac (
      .g_i   (s1_q.g),
      .p_i   (s1_q.p),
      .x_i   (s1_q.x),
      .sum_o (sum)
   );

   // All-ones sum happens only for a + b' = 2^W-1 (a = ~b') or both all-ones;
   // detected from the operands so it runs beside the carry network.
   assign neg_zero = (&s1_q.x) | ((&s1_q.a) & (&s1_q.b_n));
   assign norm_sum = (NORMALIZE && neg_zero) ? '0 : sum;

   always_comb begin
      res_d      = res_q;
      s2_valid_d = s2_valid_q;
      if (s2_load) begin
         res_d      = norm_sum;
         s2_valid_d = 1'b1;
      end else if (out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_q       <= '0;
         res_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_q       <= s1_d;
         res_q      <= res_d;
      end
   end

   assign out_valid = s2_valid_q && !rst;
   assign out_res   = rst ? '0 : res_q;

endmodule
